decode_stage: RTL and testbench

Instruction-decode (ID) stage of the MIPS R2000 pipeline. It consumes the instruction/PC pair produced by the fetch stage and owns the 32×32 register file. It resolves branches, jumps and illegal opcodes in ID and drives the `br`/`sign`/`except`/`fixed` redirect inputs back into fetch. Wrong-path instructions are squashed, and decoded operands are registered into the ID/EX pipeline register.

---
 rtl/decode_stage.sv | 257 +++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// MIPS R2000 ID stage: field decode, 32x32 register file, branch/jump/illegal resolution, ID/EX register.
// Latency: 1 cycle from inst_in/pc_in sampled to ex_*/br/sign/except; fixed is a constant.
// Backpressure: none; one instruction accepted every cycle, wrong-path slots squashed after a redirect.
module decode_stage #(
  parameter logic [31:0] EXCEPT_VECTOR = 32'h8000_0080,
  parameter int          SQUASH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic [31:0] inst_in,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        br,
  output logic [31:0] sign,
  output logic        except,
  output logic [31:0] fixed,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [5:0]  ex_opcode,
  output logic [5:0]  ex_funct,
  output logic [4:0]  ex_shamt,
  output logic [31:0] ex_rs_data,
  output logic [31:0] ex_rt_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rd_addr,
  output logic        ex_reg_write
);

  typedef enum logic {S_RUN, S_SQUASH} state_t;

  // Instruction fields
  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_shamt;
  logic [5:0]  w_funct;
  logic [15:0] w_imm16;

  assign w_op    = inst_in[31:26];
  assign w_rs    = inst_in[25:21];
  assign w_rt    = inst_in[20:16];
  assign w_rd    = inst_in[15:11];
  assign w_shamt = inst_in[10:6];
  assign w_funct = inst_in[5:0];
  assign w_imm16 = inst_in[15:0];

  // Register file and operand reads
  logic [31:0] r_rf [32];
  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;

  // A same-cycle write-back is forwarded so the decode sees the value being written.
  assign w_rs_val = (w_rs == 5'd0) ? 32'd0 :
                    (wb_en && (wb_addr == w_rs)) ? wb_data : r_rf[w_rs];
  assign w_rt_val = (w_rt == 5'd0) ? 32'd0 :
                    (wb_en && (wb_addr == w_rt)) ? wb_data : r_rf[w_rt];

  // Target arithmetic (wraps modulo 2^32)
  logic [31:0] w_pc4;
  logic [31:0] w_sext;
  logic [31:0] w_br_target;
  logic [31:0] w_j_target;

  assign w_pc4       = pc_in + 32'd4;
  assign w_sext      = {{16{w_imm16[15]}}, w_imm16};
  assign w_br_target = w_pc4 + {w_sext[29:0], 2'b00};
  assign w_j_target  = {w_pc4[31:28], inst_in[25:0], 2'b00};

  // Decode results
  logic        w_legal;
  logic        w_regwr;
  logic [4:0]  w_dst;
  logic        w_taken;
  logic [31:0] w_target;
  logic        w_zext;
  logic        w_is_jal;
  logic [31:0] w_imm_ext;

  // Classify the instruction: legality, destination, and whether it redirects fetch.
  always_comb begin
    w_legal  = 1'b0;
    w_regwr  = 1'b0;
    w_dst    = 5'd0;
    w_taken  = 1'b0;
    w_target = 32'd0;
    w_zext   = 1'b0;
    w_is_jal = 1'b0;
    case (w_op)
      6'h00: begin
        case (w_funct)
          6'h00, 6'h02, 6'h03,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A, 6'h2B: begin
            w_legal = 1'b1;
            w_regwr = 1'b1;
            w_dst   = w_rd;
          end
          6'h08: begin
            w_legal  = 1'b1;
            w_dst    = w_rd;
            w_taken  = 1'b1;
            w_target = w_rs_val;
          end
          default: ;
        endcase
      end
      6'h02: begin
        w_legal  = 1'b1;
        w_taken  = 1'b1;
        w_target = w_j_target;
      end
      6'h03: begin
        w_legal  = 1'b1;
        w_regwr  = 1'b1;
        w_dst    = 5'd31;
        w_taken  = 1'b1;
        w_target = w_j_target;
        w_is_jal = 1'b1;
      end
      6'h04: begin
        w_legal  = 1'b1;
        w_dst    = w_rt;
        w_taken  = (w_rs_val == w_rt_val);
        w_target = w_br_target;
      end
      6'h05: begin
        w_legal  = 1'b1;
        w_dst    = w_rt;
        w_taken  = (w_rs_val != w_rt_val);
        w_target = w_br_target;
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0F, 6'h23: begin
        w_legal = 1'b1;
        w_regwr = 1'b1;
        w_dst   = w_rt;
      end
      6'h0C, 6'h0D, 6'h0E: begin
        w_legal = 1'b1;
        w_regwr = 1'b1;
        w_dst   = w_rt;
        w_zext  = 1'b1;
      end
      6'h2B: begin
        w_legal = 1'b1;
        w_dst   = w_rt;
      end
      default: ;
    endcase
  end

  assign w_imm_ext = w_is_jal ? (pc_in + 32'd8) :
                     w_zext   ? {16'd0, w_imm16} : w_sext;

  // Register file: r0 is never written, whole array cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= 32'd0;
    end else if (wb_en && (wb_addr != 5'd0)) begin
      r_rf[wb_addr] <= wb_data;
    end
  end

  // Pipeline control state and registered ID/EX outputs.
  state_t      r_state;
  logic [1:0]  r_sq_cnt;
  logic        r_br;
  logic [31:0] r_sign;
  logic        r_except;
  logic        r_valid;
  logic [31:0] r_pc;
  logic [5:0]  r_opcode;
  logic [5:0]  r_funct;
  logic [4:0]  r_shamt;
  logic [31:0] r_rs_data;
  logic [31:0] r_rt_data;
  logic [31:0] r_imm;
  logic [4:0]  r_rd_addr;
  logic        r_reg_write;

  // RUN resolves redirects/exceptions; SQUASH discards the wrong-path slots that follow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_sq_cnt    <= 2'd0;
      r_br        <= 1'b0;
      r_sign      <= 32'd0;
      r_except    <= 1'b0;
      r_valid     <= 1'b0;
      r_pc        <= 32'd0;
      r_opcode    <= 6'd0;
      r_funct     <= 6'd0;
      r_shamt     <= 5'd0;
      r_rs_data   <= 32'd0;
      r_rt_data   <= 32'd0;
      r_imm       <= 32'd0;
      r_rd_addr   <= 5'd0;
      r_reg_write <= 1'b0;
    end else begin
      r_br      <= 1'b0;
      r_except  <= 1'b0;
      r_pc      <= pc_in;
      r_opcode  <= w_op;
      r_funct   <= w_funct;
      r_shamt   <= w_shamt;
      r_rs_data <= w_rs_val;
      r_rt_data <= w_rt_val;
      r_imm     <= w_imm_ext;
      r_rd_addr <= w_dst;
      case (r_state)
        S_RUN: begin
          if (!w_legal) begin
            r_except    <= 1'b1;
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_sq_cnt    <= 2'(SQUASH_CYCLES);
            r_state     <= S_SQUASH;
          end else begin
            r_valid     <= 1'b1;
            r_reg_write <= w_regwr;
            if (w_taken) begin
              r_br     <= 1'b1;
              r_sign   <= w_target;
              r_sq_cnt <= 2'(SQUASH_CYCLES);
              r_state  <= S_SQUASH;
            end
          end
        end
        S_SQUASH: begin
          r_valid     <= 1'b0;
          r_reg_write <= 1'b0;
          r_sq_cnt    <= r_sq_cnt - 2'd1;
          if (r_sq_cnt == 2'd1) r_state <= S_RUN;
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign br           = r_br;
  assign sign         = r_sign;
  assign except       = r_except;
  assign fixed        = EXCEPT_VECTOR;
  assign ex_valid     = r_valid;
  assign ex_pc        = r_pc;
  assign ex_opcode    = r_opcode;
  assign ex_funct     = r_funct;
  assign ex_shamt     = r_shamt;
  assign ex_rs_data   = r_rs_data;
  assign ex_rt_data   = r_rt_data;
  assign ex_imm       = r_imm;
  assign ex_rd_addr   = r_rd_addr;
  assign ex_reg_write = r_reg_write;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: randomized plus directed instruction stream against a reference model.
// Latency: expected entries are queued at the sampling edge and compared on the following falling edge.
// Backpressure: none; the DUT consumes one instruction per cycle.
module tb_decode_stage;

  localparam logic [31:0] EV = 32'h8000_0080;
  localparam int          SQ = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_in = 32'd0;
  logic [31:0] inst_in = 32'd0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic        br, except, ex_valid, ex_reg_write;
  logic [31:0] sign, fixed, ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [5:0]  ex_opcode, ex_funct;
  logic [4:0]  ex_shamt, ex_rd_addr;

  decode_stage #(.EXCEPT_VECTOR(EV), .SQUASH_CYCLES(SQ)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .inst_in(inst_in),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .br(br), .sign(sign), .except(except), .fixed(fixed),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_opcode(ex_opcode), .ex_funct(ex_funct),
    .ex_shamt(ex_shamt), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic        br;
    logic        exc;
    logic [31:0] sign;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        chk_imm;
    logic [31:0] imm;
    logic        rw;
    logic [4:0]  rd;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;

  // Reference model state: architectural registers, slots left to discard, last redirect target.
  logic [31:0] m_regs [32];
  int          m_sq = 0;
  logic [31:0] m_sign = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_reg(input logic [4:0] a, input logic wen,
                                         input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (wen && wa == a) return wd;
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_sq   = 0;
    m_sign = 32'd0;
  endtask

  // Drive one instruction, predict the DUT's response, queue it at the sampling edge.
  task automatic issue(input logic [31:0] pc, input logic [31:0] inst, input logic wen,
                       input logic [4:0] wa, input logic [31:0] wd);
    exp_t        e;
    logic [5:0]  op, fn;
    logic [31:0] rsv, rtv, sx, tgt;
    logic        legal, taken, rw, jal;
    logic [4:0]  dst;
    pc_in = pc; inst_in = inst; wb_en = wen; wb_addr = wa; wb_data = wd;
    op  = inst[31:26];
    fn  = inst[5:0];
    rsv = rd_reg(inst[25:21], wen, wa, wd);
    rtv = rd_reg(inst[20:16], wen, wa, wd);
    sx  = {{16{inst[15]}}, inst[15:0]};
    jal = (op == 6'h03);
    taken = 1'b0; tgt = 32'd0; rw = 1'b0; dst = 5'd0;
    if (op == 6'h00) begin
      legal = (fn inside {6'h00, 6'h02, 6'h03, 6'h08, [6'h20:6'h27], 6'h2A, 6'h2B});
      rw    = legal && fn != 6'h08;
      dst   = inst[15:11];
      if (fn == 6'h08) begin taken = 1'b1; tgt = rsv; end
    end else if (op == 6'h02 || jal) begin
      legal = 1'b1;
      taken = 1'b1;
      tgt   = {pc[31:28] + ((pc[27:0] > 28'hFFF_FFFB) ? 4'd1 : 4'd0), inst[25:0], 2'b00};
      rw    = jal;
      dst   = 5'd31;
    end else begin
      legal = (op inside {6'h04, 6'h05, [6'h08:6'h0F], 6'h23, 6'h2B});
      rw    = legal && !(op inside {6'h04, 6'h05, 6'h2B});
      dst   = inst[20:16];
      if (op == 6'h04) begin taken = (rsv == rtv); tgt = pc + 4 + sx * 4; end
      if (op == 6'h05) begin taken = (rsv != rtv); tgt = pc + 4 + sx * 4; end
    end
    e = '0;
    e.pc = pc; e.op = op; e.funct = fn; e.shamt = inst[10:6]; e.rs = rsv; e.rt = rtv;
    e.rd = dst;
    e.chk_imm = legal && op != 6'h00 && op != 6'h02;
    e.imm = jal ? pc + 8 : (op inside {6'h0C, 6'h0D, 6'h0E}) ? {16'd0, inst[15:0]} : sx;
    if (m_sq > 0) begin
      m_sq--;
    end else if (!legal) begin
      e.exc = 1'b1;
      m_sq  = SQ;
    end else begin
      e.valid = 1'b1;
      e.rw    = rw;
      if (taken) begin
        e.br   = 1'b1;
        m_sign = tgt;
        m_sq   = SQ;
      end
    end
    e.sign = m_sign;
    if (wen && wa != 5'd0) m_regs[wa] = wd;
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask

  // Monitor: one expected response per sampled instruction, checked on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && q.size() > 0) begin
      e = q.pop_front();
      check("ex_valid", 32'(ex_valid), 32'(e.valid));
      check("br", 32'(br), 32'(e.br));
      check("except", 32'(except), 32'(e.exc));
      check("sign", sign, e.sign);
      check("fixed", fixed, EV);
      check("ex_reg_write", 32'(ex_reg_write), 32'(e.rw));
      if (e.valid) begin
        check("ex_pc", ex_pc, e.pc);
        check("ex_opcode", 32'(ex_opcode), 32'(e.op));
        check("ex_funct", 32'(ex_funct), 32'(e.funct));
        check("ex_shamt", 32'(ex_shamt), 32'(e.shamt));
        check("ex_rs_data", ex_rs_data, e.rs);
        check("ex_rt_data", ex_rt_data, e.rt);
        if (e.rw) check("ex_rd_addr", 32'(ex_rd_addr), 32'(e.rd));
        if (e.chk_imm) check("ex_imm", ex_imm, e.imm);
      end
    end
  end

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_br"}, 32'(br), 32'd0);
    check({tag, "_except"}, 32'(except), 32'd0);
    check({tag, "_ex_valid"}, 32'(ex_valid), 32'd0);
    check({tag, "_sign"}, sign, 32'd0);
    check({tag, "_fixed"}, fixed, EV);
    check({tag, "_ex_pc"}, ex_pc, 32'd0);
    check({tag, "_ex_rs_data"}, ex_rs_data, 32'd0);
    check({tag, "_ex_reg_write"}, 32'(ex_reg_write), 32'd0);
  endtask

  logic [5:0] r_fns [12] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h20, 6'h21, 6'h22, 6'h23,
                             6'h24, 6'h25, 6'h2A, 6'h2B};
  logic [5:0] i_ops [12] = '{6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                             6'h0E, 6'h0F, 6'h23, 6'h2B};

  initial begin
    logic [31:0] inst, pc, wd;
    model_reset();
    #3;
    check_reset_outputs("reset");
    #4 rst = 1'b0;
    @(posedge clk); #1;

    // Load r1 = r2 = 7, then write-through forwarding: add r3,r5,r0 with r5 written same cycle.
    issue(32'h0, 32'h0, 1'b1, 5'd1, 32'd7);
    issue(32'h4, 32'h0, 1'b1, 5'd2, 32'd7);
    issue(32'h8, rtype(5'd5, 5'd0, 5'd3, 6'h20), 1'b1, 5'd5, 32'h1234);

    // Taken beq r1,r2,+3 at 0x40: two squashed slots, third live.
    issue(32'h40, {6'h04, 5'd1, 5'd2, 16'd3}, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) issue(32'h44 + 4 * i, rtype(5'd1, 5'd2, 5'd4, 6'h21), 1'b0, 5'd0, 32'd0);

    // Untaken bne, following instruction live.
    issue(32'h80, {6'h05, 5'd1, 5'd2, 16'd3}, 1'b0, 5'd0, 32'd0);
    issue(32'h84, rtype(5'd1, 5'd2, 5'd6, 6'h25), 1'b0, 5'd0, 32'd0);

    // Illegal opcode, j inside the squash window, then live.
    issue(32'h100, {6'h3F, 26'd0}, 1'b0, 5'd0, 32'd0);
    issue(32'h104, {6'h02, 26'd5}, 1'b0, 5'd0, 32'd0);
    issue(32'h108, {6'h02, 26'd9}, 1'b0, 5'd0, 32'd0);
    issue(32'h10C, rtype(5'd1, 5'd0, 5'd7, 6'h20), 1'b0, 5'd0, 32'd0);

    // jal at 0xF000_0000, then write-back to r0 and later r0 reads.
    issue(32'hF000_0000, {6'h03, 26'd1}, 1'b0, 5'd0, 32'd0);
    issue(32'hF000_0004, 32'h0, 1'b0, 5'd0, 32'd0);
    issue(32'hF000_0008, 32'h0, 1'b0, 5'd0, 32'd0);
    issue(32'h200, rtype(5'd0, 5'd1, 5'd8, 6'h20), 1'b1, 5'd0, 32'hDEAD_BEEF);
    issue(32'h204, rtype(5'd0, 5'd0, 5'd9, 6'h20), 1'b0, 5'd0, 32'd0);

    // Reset one cycle into SQUASH clears outputs asynchronously.
    issue(32'h300, {6'h04, 5'd1, 5'd2, 16'hFFFF}, 1'b0, 5'd0, 32'd0);
    issue(32'h304, 32'h0, 1'b0, 5'd0, 32'd0);
    #6 rst = 1'b1;
    #1;
    check_reset_outputs("midsquash_reset");
    model_reset();
    @(negedge clk); #2 rst = 1'b0;
    issue(32'h400, rtype(5'd0, 5'd0, 5'd10, 6'h20), 1'b0, 5'd0, 32'd0);

    // Randomized stream.
    for (int n = 0; n < 3000; n++) begin
      int k;
      k  = $urandom_range(0, 9);
      pc = $urandom();
      pc[1:0] = 2'b00;
      if (k <= 3)
        inst = {6'h00, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom),
                5'($urandom), (k == 3) ? 6'($urandom) : r_fns[$urandom_range(0, 11)]};
      else if (k <= 7)
        inst = {i_ops[$urandom_range(0, 11)], 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 16'($urandom)};
      else if (k == 8)
        inst = {5'b00001, 1'($urandom), 26'($urandom)};
      else
        inst = $urandom();
      wd = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom();
      issue(pc, inst, 1'($urandom), 5'($urandom_range(0, 7)), wd);
    end

    repeat (2) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
